// File: rtl/noc_pkg.sv
// Shared router-port definitions: port directions, XY decision indices, buffer FSM
// states, and the per-direction route mapping and legality helpers.
package noc_pkg;

    localparam int DIR_SOUTH = 0;
    localparam int DIR_WEST  = 1;
    localparam int DIR_NORTH = 2;
    localparam int DIR_EAST  = 3;
    localparam int DIR_LOCAL = 4;

    // Bit positions inside the 5-bit XY decision vector.
    localparam int D_XGT = 0;
    localparam int D_XLT = 1;
    localparam int D_YGT = 2;
    localparam int D_YLT = 3;
    localparam int D_LOC = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FWD,
        DROP
    } state_e;

    // Narrow ports (west/east) use only the low two bits of the result.
    function automatic logic [3:0] route_map(input int dir, input logic [4:0] d);
        logic [3:0] m;
        m = '0;
        case (dir)
            DIR_SOUTH: m = {d[D_LOC], d[D_YGT], d[D_XLT], d[D_YLT]};
            DIR_WEST:  m = {2'b00, d[D_LOC], d[D_YGT]};
            DIR_NORTH: m = {d[D_LOC], d[D_YGT], d[D_YLT], d[D_XGT]};
            DIR_EAST:  m = {2'b00, d[D_LOC], d[D_YLT]};
            default:   m = {d[D_YGT], d[D_XLT], d[D_YLT], d[D_XGT]};
        endcase
        return m;
    endfunction

    function automatic logic route_illegal(input int dir, input logic [4:0] d);
        logic bad;
        bad = 1'b0;
        case (dir)
            DIR_SOUTH: bad = d[D_XGT];
            DIR_WEST:  bad = d[D_XGT] | d[D_XLT] | d[D_YLT];
            DIR_NORTH: bad = d[D_XLT];
            DIR_EAST:  bad = d[D_XGT] | d[D_XLT] | d[D_YGT];
            default:   bad = d[D_LOC];
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO of PD entries (any PD >= 2) with registered occupancy count.
// No fall-through: a word written at one edge is readable from the next cycle.
module sync_fifo #(
    parameter int W  = 17,
    parameter int PD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = (PD > 1) ? $clog2(PD) : 1;
    localparam int CW = $clog2(PD + 1);

    logic [W-1:0]  mem_q [PD];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(PD));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(PD - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the zeroed count already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/sync_inp_buf.sv
// Router input port buffer: FIFO plus registered XY route decision. Legal frames
// are requested and forwarded until the tail; illegal frames are drained and dropped.
module sync_inp_buf
    import noc_pkg::*;
#(
    parameter int DIR = 0,
    parameter int DW  = 16,
    parameter int PD  = 4,
    parameter int AW  = 4,
    parameter int RN  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    input  logic          in_eof,
    output logic          in_rdy,
    output logic          out_vld,
    output logic [DW-1:0] out_data,
    output logic          out_eof,
    input  logic          out_rdy,
    input  logic [AW-1:0] addrx,
    input  logic [AW-1:0] addry,
    output logic [RN-1:0] deco,
    input  logic          gnt,
    output logic          rt_err
);

    logic [DW:0]   fifo_rdata;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW-1:0] head_x, head_y;
    logic          head_eof;
    logic [4:0]    dec;
    logic [4:0]    route_q, route_d;
    logic [3:0]    deco_full;
    state_e        state_q, state_d;

    // in_rdy is held low while reset is asserted, not only after the reset edge.
    assign in_rdy    = rst_n & ~fifo_full;
    assign fifo_push = in_vld & in_rdy;

    sync_fifo #(
        .W  (DW + 1),
        .PD (PD)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({in_eof, in_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_x   = fifo_rdata[AW-1:0];
    assign head_y   = fifo_rdata[2*AW-1:AW];
    assign head_eof = fifo_rdata[DW];
    assign out_data = fifo_rdata[DW-1:0];
    assign out_eof  = head_eof;

    always_comb begin
        dec        = '0;
        dec[D_XGT] = (head_x > addrx);
        dec[D_XLT] = (head_x < addrx);
        dec[D_YGT] = (head_x == addrx) && (head_y > addry);
        dec[D_YLT] = (head_x == addrx) && (head_y < addry);
        dec[D_LOC] = (head_x == addrx) && (head_y == addry);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        fifo_pop  = 1'b0;
        out_vld   = 1'b0;
        deco_full = '0;
        rt_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    route_d = dec;
                    state_d = route_illegal(DIR, dec) ? DROP : REQ;
                end
            end
            REQ: begin
                deco_full = route_map(DIR, route_q);
                if (gnt) state_d = FWD;
            end
            FWD: begin
                deco_full = route_map(DIR, route_q);
                out_vld   = ~fifo_empty & gnt;
                fifo_pop  = out_vld & out_rdy;
                if (fifo_pop && head_eof) state_d = IDLE;
            end
            DROP: begin
                rt_err   = 1'b1;
                fifo_pop = ~fifo_empty;
                if (fifo_pop && head_eof) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign deco = deco_full[RN-1:0];

endmodule

// File: tb/tb_sync_inp_buf.sv
// Scoreboard bench: unit 0 is a local port (DIR=4, at 2,3), unit 1 a south port (DIR=0, at 2,1).
module tb_sync_inp_buf;
    import noc_pkg::*;

    localparam int DW = 16;
    localparam int PD = 4;
    localparam int AW = 4;
    localparam int RN = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_vld  [2];
    logic [DW-1:0] in_data [2];
    logic          in_eof  [2];
    logic          in_rdy  [2];
    logic          out_vld [2];
    logic [DW-1:0] out_data[2];
    logic          out_eof [2];
    logic          out_rdy [2];
    logic [AW-1:0] addrx   [2];
    logic [AW-1:0] addry   [2];
    logic [RN-1:0] deco    [2];
    logic          gnt     [2];
    logic          rt_err  [2];
    logic          auto_gnt[2];

    logic [DW:0] exp_q0[$];
    logic [DW:0] exp_q1[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] t2_d     [3]  = '{16'h0032, 16'h1111, 16'h2222};
    logic [6:0]  t2_rt         = 7'b0011100;
    logic [15:0] t3_d     [6]  = '{16'hC035, 16'hC101, 16'hC202, 16'hC303, 16'hC404, 16'hC505};
    logic [15:0] t4_d     [4]  = '{16'hB012, 16'hB101, 16'hB202, 16'hB303};
    logic [6:0]  t4_gnt        = 7'b0111011;
    logic [6:0]  t4_ov         = 7'b0111010;
    logic [15:0] t5_d     [4]  = '{16'hD135, 16'hE072, 16'hE1AA, 16'hE2BB};
    logic [3:0]  t5_eof        = 4'b1001;
    logic [3:0]  t5_deco  [10] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};

    sync_inp_buf #(.DIR(DIR_LOCAL), .DW(DW), .PD(PD), .AW(AW), .RN(RN)) u_dut_loc (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld[0]), .in_data(in_data[0]), .in_eof(in_eof[0]), .in_rdy(in_rdy[0]),
        .out_vld(out_vld[0]), .out_data(out_data[0]), .out_eof(out_eof[0]), .out_rdy(out_rdy[0]),
        .addrx(addrx[0]), .addry(addry[0]), .deco(deco[0]), .gnt(gnt[0]), .rt_err(rt_err[0])
    );

    sync_inp_buf #(.DIR(DIR_SOUTH), .DW(DW), .PD(PD), .AW(AW), .RN(RN)) u_dut_south (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld[1]), .in_data(in_data[1]), .in_eof(in_eof[1]), .in_rdy(in_rdy[1]),
        .out_vld(out_vld[1]), .out_data(out_data[1]), .out_eof(out_eof[1]), .out_rdy(out_rdy[1]),
        .addrx(addrx[1]), .addry(addry[1]), .deco(deco[1]), .gnt(gnt[1]), .rt_err(rt_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int u, input logic [DW:0] v);
        if (u == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic send_flit(input int u, input logic [DW-1:0] d, input logic e, input logic fwd);
        bit done;
        done = 1'b0;
        in_vld[u] = 1'b1; in_data[u] = d; in_eof[u] = e;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_rdy[u]) begin
                done = 1'b1;
                if (fwd) push_exp(u, {e, d});
            end
            next_cycle();
        end
        in_vld[u] = 1'b0; in_eof[u] = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL send u%0d: in_rdy got 0, want 1 within 20 cycles", u);
        end
    endtask

    task automatic drain(input int u, input string name);
        for (int c = 0; c < 40 && ((u == 0) ? exp_q0.size() : exp_q1.size()) != 0; c++)
            next_cycle();
        check(name, (u == 0) ? exp_q0.size() : exp_q1.size(), 0);
        next_cycle();
        next_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst u%0d in_rdy", u),  in_rdy[u],  0);
            check($sformatf("rst u%0d out_vld", u), out_vld[u], 0);
            check($sformatf("rst u%0d deco", u),    deco[u],    0);
            check($sformatf("rst u%0d rt_err", u),  rt_err[u],  0);
        end
        next_cycle();
        rst_n = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("post-rst u%0d in_rdy", u),  in_rdy[u],  1);
            check($sformatf("post-rst u%0d out_vld", u), out_vld[u], 0);
        end
        next_cycle();
    endtask

    // Scoreboard monitor: every accepted output flit must match the oldest expectation.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n) begin
            if (out_vld[0] && out_rdy[0]) begin
                if (exp_q0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL u0 flit: got 0x%0h, want no flit", {out_eof[0], out_data[0]});
                end else begin
                    e = exp_q0.pop_front();
                    check("u0 flit", {out_eof[0], out_data[0]}, e);
                end
            end
            if (out_vld[1] && out_rdy[1]) begin
                if (exp_q1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL u1 flit: got 0x%0h, want no flit", {out_eof[1], out_data[1]});
                end else begin
                    e = exp_q1.pop_front();
                    check("u1 flit", {out_eof[1], out_data[1]}, e);
                end
            end
        end
    end

    // Simple arbiter model: grant whatever is requested, sampled after each edge.
    always @(posedge clk) begin
        #2;
        for (int u = 0; u < 2; u++)
            if (auto_gnt[u]) gnt[u] = |deco[u];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_vld[u] = 1'b0; in_data[u] = '0; in_eof[u] = 1'b0;
            out_rdy[u] = 1'b1; gnt[u] = 1'b0; auto_gnt[u] = 1'b0;
        end
        addrx[0] = 4'd2; addry[0] = 4'd3;
        addrx[1] = 4'd2; addry[1] = 4'd1;
        #1;
        do_reset();

        // Single-flit frame east of the local router: latency of deco and out_vld.
        in_vld[0] = 1'b1; in_data[0] = 16'hA135; in_eof[0] = 1'b1;
        push_exp(0, {1'b1, 16'hA135});
        @(negedge clk); check("t1 in_rdy", in_rdy[0], 1);
        next_cycle(); in_vld[0] = 1'b0; in_eof[0] = 1'b0;
        @(negedge clk); check("t1 deco t+1", deco[0], 0);
        next_cycle(); gnt[0] = 1'b1;
        @(negedge clk); check("t1 deco t+2", deco[0], 4'b0001); check("t1 out_vld t+2", out_vld[0], 0);
        next_cycle();
        @(negedge clk); check("t1 out_vld t+3", out_vld[0], 1); check("t1 deco t+3", deco[0], 4'b0001);
        next_cycle(); gnt[0] = 1'b0;
        @(negedge clk); check("t1 deco idle", deco[0], 0); check("t1 out_vld idle", out_vld[0], 0);
        check("t1 drained", exp_q0.size(), 0);
        next_cycle();

        // Local-to-local frame is illegal and must be dropped, three cycles of rt_err.
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                in_vld[0] = 1'b1; in_data[0] = t2_d[k]; in_eof[0] = (k == 2);
            end else begin
                in_vld[0] = 1'b0; in_eof[0] = 1'b0;
            end
            @(negedge clk);
            check($sformatf("t2 rt_err c%0d", k), rt_err[0], t2_rt[k]);
            check($sformatf("t2 deco c%0d", k), deco[0], 0);
            check($sformatf("t2 out_vld c%0d", k), out_vld[0], 0);
            next_cycle();
        end
        check("t2 in_rdy empty", in_rdy[0], 1);

        // Backpressure: six flits offered against a stalled output, FIFO wraps.
        auto_gnt[0] = 1'b1; out_rdy[0] = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            if (c == 8) out_rdy[0] = 1'b1;
            in_vld[0] = 1'b1; in_data[0] = t3_d[idx]; in_eof[0] = (idx == 5);
            @(negedge clk);
            if (in_rdy[0]) begin
                push_exp(0, {(idx == 5), t3_d[idx]});
                idx++;
            end
            if (c == 7) begin
                check("t3 pushes when full", idx, 4);
                check("t3 in_rdy full", in_rdy[0], 0);
            end
            next_cycle();
        end
        in_vld[0] = 1'b0; in_eof[0] = 1'b0;
        check("t3 all accepted", idx, 6);
        drain(0, "t3 drained");
        auto_gnt[0] = 1'b0; gnt[0] = 1'b0;

        // South port, local frame, grant toggled mid-frame.
        gnt[1] = 1'b0; out_rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) send_flit(1, t4_d[k], (k == 3), 1'b1);
        for (int c = 0; c < 7; c++) begin
            gnt[1] = t4_gnt[c];
            @(negedge clk);
            check($sformatf("t4 out_vld c%0d", c), out_vld[1], t4_ov[c]);
            check($sformatf("t4 deco c%0d", c), deco[1], (c < 6) ? 4'b1000 : 4'b0000);
            next_cycle();
        end
        gnt[1] = 1'b0;
        check("t4 no loss", exp_q1.size(), 0);

        // Back-to-back frames: one idle cycle between requests, each decoded on its own head.
        auto_gnt[0] = 1'b1; out_rdy[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                in_vld[0] = 1'b1; in_data[0] = t5_d[k]; in_eof[0] = t5_eof[k];
                push_exp(0, {t5_eof[k], t5_d[k]});
            end else begin
                in_vld[0] = 1'b0; in_eof[0] = 1'b0;
            end
            @(negedge clk);
            if (k < 4) check($sformatf("t5 in_rdy c%0d", k), in_rdy[0], 1);
            check($sformatf("t5 deco c%0d", k), deco[0], t5_deco[k]);
            next_cycle();
        end
        drain(0, "t5 drained");

        // Reset while forwarding with two flits stored.
        out_rdy[0] = 1'b0;
        send_flit(0, 16'hF135, 1'b0, 1'b0);
        send_flit(0, 16'hF1FF, 1'b0, 1'b0);
        idx = 0;
        for (int c = 0; c < 10 && idx == 0; c++) begin
            @(negedge clk);
            if (out_vld[0]) idx = 1;
            next_cycle();
        end
        check("t6 reached FWD", idx, 1);
        do_reset();
        auto_gnt[0] = 1'b0; gnt[0] = 1'b0;
        check("t6 deco after rst", deco[0], 0);
        auto_gnt[0] = 1'b1; out_rdy[0] = 1'b1;
        send_flit(0, 16'h9135, 1'b1, 1'b1);
        drain(0, "t6 fresh frame");
        auto_gnt[0] = 1'b0; gnt[0] = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_inp_buf.md
Name: sync_inp_buf

Overview:
Clocked, parametrised input buffer for the wormhole/SDM router port. It is the synchronous successor to the asynchronous pipelined input buffer.
- Stores flits in a PD-deep FIFO.
- Decodes XY routing from binary coordinates in the head flit and holds the request until the tail flit leaves.
- Drops frames whose route is illegal for the port, instead of stalling.
- Sits between the link receiver and the switch-allocator/crossbar input.

Parameters:
DIR, 0, port direction: 0 south, 1 west, 2 north, 3 east, 4 local
DW, 16, flit data width (DW >= 2*AW)
PD, 4, FIFO depth in flits (>= 2, need not be a power of two)
AW, 4, binary coordinate width per axis
RN, 4, request width; must be 4 for DIR 0/2/4 and 2 for DIR 1/3

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
in_vld  in  1  upstream flit valid
in_data  in  DW  upstream flit; in a head flit, [AW-1:0] is target x and [2AW-1:AW] is target y
in_eof  in  1  tail-flit marker
in_rdy  out  1  buffer can accept a flit
out_vld  out  1  flit valid towards crossbar
out_data  out  DW  FIFO head data
out_eof  out  1  FIFO head tail marker
out_rdy  in  1  crossbar accepts flit
addrx  in  AW  local router x (quasi-static)
addry  in  AW  local router y (quasi-static)
deco  out  RN  routing request to arbiters, at most one bit high
gnt  in  1  arbiter grant for the asserted deco bit; held until the tail flit is accepted
rt_err  out  1  high while an illegal frame is being dropped

Behaviour:
Reset
- rst_n=0 at an edge empties the FIFO, pointers and count go to 0, state goes to IDLE.
- Immediately after that edge: in_rdy=0 during reset, out_vld=0, deco=0, rt_err=0.
- Reset mid-frame discards all stored flits. No partial-frame recovery.

FIFO
- Push when in_vld & in_rdy.
- in_rdy = (count < PD). There is no push when full, even if a pop occurs in the same cycle.
- Pop on a forwarded or dropped flit.
- Simultaneous push and pop keeps count unchanged.
- Pointers wrap modulo PD.
- No fall-through: a flit pushed at edge t is at the head from t+1.

Route decision (at the FIFO head in IDLE)
- Comparisons are unsigned, between head x/y and addrx/addry.
- Decision vector d:
  - d0 = x greater
  - d1 = x less
  - d2 = (x equal) & (y greater)
  - d3 = (x equal) & (y less)
  - d4 = (x equal) & (y equal)
- deco mapping:
  - DIR0 = {d4,d2,d1,d3}
  - DIR1 = {d4,d2}
  - DIR2 = {d4,d2,d3,d0}
  - DIR3 = {d4,d3}
  - DIR4 = {d2,d1,d3,d0}
- Illegal route: DIR0 d0; DIR1 d0|d1|d3; DIR2 d1; DIR3 d0|d1|d2; DIR4 d4.

State machine (decision registered, held in a 5-bit route register)
- IDLE: if FIFO non-empty, latch d. Next state is DROP if illegal, otherwise REQ.
- REQ: deco = mapped route register. On gnt=1, next state is FWD.
- FWD:
  - deco stays asserted.
  - out_vld = nonempty & gnt.
  - Pop on out_vld & out_rdy.
  - If the popped flit has eof, next state is IDLE and deco=0 from the next cycle.
- DROP:
  - deco=0, rt_err=1, out_vld=0.
  - Pop every cycle the FIFO is non-empty.
  - Popped eof leads to IDLE.
- Head flit forwarding: the head flit is forwarded, not stripped. A single-flit frame (head is also tail) completes in one pop.
- Latency: head pushed at t gives deco high from t+2. With gnt at t+2, out_vld is high at t+3.
- gnt low during FWD stalls output without losing state.
- in_vld while in_rdy=0 has no effect.
- addrx/addry changes are sampled only in IDLE.

Decomposition:
- Package noc_pkg holds:
  - DIR_SOUTH..DIR_LOCAL constants
  - decision index constants D_XGT, D_XLT, D_YGT, D_YLT, D_LOC
  - the state enum {IDLE, REQ, FWD, DROP}
- Sub-module sync_fifo #(W, PD) provides storage with count, full and empty. Width W = DW+1 (data plus eof).
- Route decode and state machine live in the top module.

Test Plan:
- DIR=4, addrx=2, addry=3. Head x=5,y=3 with eof=1 pushed at t -> deco=4'b0001 at t+2; gnt at t+2 -> out_vld at t+3; after pop, deco=0 and state is IDLE.
- DIR=4, x=2,y=3 (local-to-local, illegal) 3-flit frame -> rt_err=1 for 3 cycles, deco=0, out_vld never high, FIFO empties.
- PD=4, out_rdy=0, 6 flits offered -> in_rdy drops after 4 pushes. Enabling out_rdy then gives exactly 6 flits out, in order, with wrap-around verified.
- DIR=0, x=2,y=1, gnt toggled 1,0,1 mid-frame -> out_vld follows gnt, no flit is duplicated or lost, and deco stays 4'b1000 until the tail.
- Back-to-back frames (1-flit, then 3-flit) -> deco deasserts for one IDLE cycle between frames, and the second route is decoded from its own head.
- rst_n=0 mid-FWD with 2 flits stored -> next cycle out_vld=0, deco=0, count 0, in_rdy=0 until rst_n=1.
